// File: rtl/chunked_add_sequencer_pkg.sv
// Shared mini-cpu definitions: datapath width, sequencer state encoding and
// the debug view exported by the chunked adder.
package mini_cpu_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic   sub;
    state_t state;
  } dbg_t;

  // Counter width that stays legal when only one chunk cycle exists.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ripple_carry_adder.sv
// Purely combinational ripple-carry adder, xlen bits wide, with carry in/out.
module ripple_carry_adder #(
  parameter int xlen = 8
) (
  input  logic [xlen-1:0] i_a,
  input  logic [xlen-1:0] i_b,
  input  logic            i_cin,
  output logic [xlen-1:0] o_sum,
  output logic            o_cout
);

  logic w_c;

  always_comb begin
    w_c   = i_cin;
    o_sum = '0;
    for (int i = 0; i < xlen; i++) begin
      o_sum[i] = i_a[i] ^ i_b[i] ^ w_c;
      w_c      = (i_a[i] & i_b[i]) | (w_c & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c;
  end

endmodule

// File: rtl/chunked_add_sequencer.sv
// Wide add/subtract built by time-sharing one CHUNK-bit ripple adder over
// WIDTH/CHUNK cycles, with valid/ready handshakes on operands and result.
module chunked_add_sequencer
  import mini_cpu_pkg::*;
#(
  parameter int WIDTH = XLEN,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output dbg_t             o_dbg
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NCHUNK - 1);

  // Handshake rule: a transfer happens on a rising edge where valid and ready
  // are both high; valid never depends on ready, and result outputs stay
  // frozen while out_valid is high and out_ready is low.

  state_t r_state;
  state_t w_next;

  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic [CNT_W-1:0] r_cnt;
  logic             r_carry;
  logic             r_sub;
  logic             r_a_msb;
  logic             r_bx_msb;

  logic             w_accept;
  logic [CHUNK-1:0] w_add_sum;
  logic             w_add_cout;
  logic [WIDTH-1:0] w_a_next;
  logic [WIDTH-1:0] w_b_next;
  logic [WIDTH-1:0] w_sum_next;

  ripple_carry_adder #(
    .xlen (CHUNK)
  ) u_rca (
    .i_a    (r_a_sh[CHUNK-1:0]),
    .i_b    (r_b_sh[CHUNK-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

  // Concatenate before shifting so CHUNK == WIDTH needs no special case.
  assign w_a_next   = WIDTH'({{CHUNK{1'b0}}, r_a_sh} >> CHUNK);
  assign w_b_next   = WIDTH'({{CHUNK{1'b0}}, r_b_sh} >> CHUNK);
  assign w_sum_next = WIDTH'({w_add_sum, r_sum_sh} >> CHUNK);

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    w_accept  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_cnt == CNT_LAST) w_next = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_a_sh   <= '0;
      r_b_sh   <= '0;
      r_sum_sh <= '0;
      r_cnt    <= '0;
      r_carry  <= 1'b0;
      r_sub    <= 1'b0;
      r_a_msb  <= 1'b0;
      r_bx_msb <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        // Subtract is a + ~b + 1: invert b once here, seed the carry with 1.
        r_a_sh   <= a;
        r_b_sh   <= b ^ {WIDTH{sub}};
        r_carry  <= sub;
        r_cnt    <= '0;
        r_sub    <= sub;
        r_a_msb  <= a[WIDTH-1];
        r_bx_msb <= b[WIDTH-1] ^ sub;
      end else if (r_state == ST_RUN) begin
        r_a_sh   <= w_a_next;
        r_b_sh   <= w_b_next;
        r_sum_sh <= w_sum_next;
        r_carry  <= w_add_cout;
        r_cnt    <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    sum       = '0;
    carry_out = 1'b0;
    overflow  = 1'b0;
    if (r_state == ST_DONE) begin
      sum       = r_sum_sh;
      carry_out = r_carry;
      overflow  = (r_a_msb == r_bx_msb) && (r_sum_sh[WIDTH-1] != r_a_msb);
    end
  end

  assign o_dbg.sub   = r_sub;
  assign o_dbg.state = r_state;

endmodule

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
- Multi-cycle wide adder/subtractor. It time-shares one narrow ripple_carry_adder instance, CHUNK bits wide, across WIDTH/CHUNK cycles.
- The carry is registered between chunks.
- Valid/ready handshake on both the operand side and the result side.
- Sits between the decode/issue logic and writeback in mini-cpu, wherever area matters more than single-cycle add latency.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be an integer multiple of CHUNK.
- CHUNK, 8, width of the shared ripple_carry_adder (its xlen). Must be at least 1.
- NCHUNK, WIDTH/CHUNK, derived number of chunk cycles. Localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  block can accept operands.
- a  input  WIDTH  first operand.
- b  input  WIDTH  second operand.
- sub  input  1  1 = a - b, 0 = a + b.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- sum  output  WIDTH  result (a+b or a-b, modulo 2^WIDTH).
- carry_out  output  1  carry out of bit WIDTH-1. For a subtract this means "no borrow".
- overflow  output  1  signed two's-complement overflow.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - state = IDLE.
  - in_ready = 1 (combinational from state).
  - out_valid = 0.
  - sum, carry_out and overflow = 0.
  - Chunk counter, operand shift registers and the carry register are all 0.
- States: IDLE, RUN, DONE. in_ready = (state == IDLE). out_valid = (state == DONE).
- IDLE:
  - On in_valid && in_ready, latch a into a_sh, and latch b ^ {WIDTH{sub}} into b_sh.
  - Set carry_reg = sub and cnt = 0. Latch sub_r = sub and the operand MSBs a_msb and bx_msb.
  - Next state = RUN. in_valid without acceptance has no effect.
- RUN, one chunk per cycle:
  - The adder sees a_sh[CHUNK-1:0], b_sh[CHUNK-1:0] and carry_reg.
  - Adder sum is shifted into the top of sum_sh, and sum_sh shifts right by CHUNK.
  - a_sh and b_sh shift right by CHUNK.
  - carry_reg takes the adder carry_out. cnt increments.
  - When cnt == NCHUNK-1 at the clock edge, next state = DONE.
- DONE:
  - sum = sum_sh, carry_out = carry_reg.
  - overflow = (a_msb == bx_msb) && (sum[WIDTH-1] != a_msb).
  - Outputs are held stable while out_valid && !out_ready.
  - On out_ready, next state = IDLE.
- Latency: operands accepted at edge E. out_valid is first high in the cycle after edge E+NCHUNK, i.e. NCHUNK cycles of RUN.
- Throughput: one operation per NCHUNK+2 cycles at most. No accept in DONE, even on the same edge that out_ready completes.
- Inputs a, b and sub are don't-care outside the accepting edge. Changing them during RUN or DONE has no effect.
- NCHUNK = 1 is legal: RUN lasts one cycle.
- Reset mid-RUN or mid-DONE: immediate return to the reset values. The in-flight result is discarded and no out_valid pulse occurs.
- Wrap-around: the sum is modulo 2^WIDTH. The carry out of the final chunk goes only to carry_out.
- The adder is purely combinational. No chunk result depends on a value from the same cycle other than carry_reg.

Decomposition:
- Shared package mini_cpu_pkg:
  - state encoding constants ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - the WIDTH default, XLEN = 32.
- Sub-module: one instance of the existing ripple_carry_adder with xlen = CHUNK.
- No new sub-modules. The FSM, counter and shift registers stay in this module.

Test Plan:
- Add, WIDTH=32, CHUNK=8:
  - Stimulus: a=0x0000_00FF, b=0x0000_0001, sub=0.
  - Required: out_valid 4 cycles after accept; sum=0x0000_0100, carry_out=0, overflow=0. Also checks carry propagation across a chunk boundary.
- Unsigned wrap:
  - Stimulus: a=0xFFFF_FFFF, b=0x0000_0001, sub=0.
  - Required: sum=0x0000_0000, carry_out=1, overflow=0.
- Subtract and signed overflow:
  - Stimulus 1: a=0x8000_0000, b=0x0000_0001, sub=1. Required: sum=0x7FFF_FFFF, carry_out=1, overflow=1.
  - Stimulus 2: a=3, b=5, sub=1. Required: sum=0xFFFF_FFFE, carry_out=0, overflow=0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 5 cycles after out_valid; toggle a and b meanwhile.
  - Required: sum and flags stable; in_ready=0 throughout; single handshake on out_ready=1; in_ready=1 on the next cycle.
- Reset mid-operation:
  - Stimulus: accept a=0x1234_5678, b=0x1111_1111, then assert rst after 2 RUN cycles.
  - Required: in_ready=1, out_valid=0 and sum=0 immediately, with no result emitted.
  - Then accept a=0x1234_5678, b=0x1111_1111 again. Required: sum=0x2345_6789.
- Parameter sweep:
  - Stimulus: CHUNK in {1, 4, 32} with WIDTH=32, against 1000 random operands compared to a behavioural reference.
  - Required: all results match; latency is exactly NCHUNK cycles of RUN.
